usrt_tx_arbiter: RTL and testbench
==================================

Name: usrt_tx_arbiter

Overview:
- Round-robin scheduler that shares a single txshift serializer among NUM_REQ byte requesters.
- Grants one requester at a time and latches its byte into the serializer.
- Holds the serializer enable until the frame-complete edge on Pready, then acknowledges the requester.
- Enforces a minimum idle gap between frames and aborts frames that never complete, using a watchdog.
- Sits between the host-side requesters (register bank, protocol engines) and the txshift instance; baud configuration stays with txshift.

Parameters:
- NUM_REQ, 4: number of requesters; legal range 2..8.
- GAP_CYCLES, 16: Pclk cycles of enable-low idle between frames; values below 1 are treated as 1.
- TIMEOUT_CYCLES, 65535: maximum BUSY cycles before abort; 0 disables the watchdog; 16-bit counter.

Ports:
- i_Pclk  in  1  system clock; all logic on posedge.
- i_Reset  in  1  synchronous, active-high reset.
- i_Req  in  NUM_REQ  per-requester level request; held until o_Ack or o_Err.
- i_Data  in  8*NUM_REQ  requester k byte at bits [8k+7:8k].
- o_Grant  out  NUM_REQ  one-hot; high for the owning requester while BUSY.
- o_Ack  out  NUM_REQ  one-cycle pulse: requester's frame completed.
- o_Err  out  NUM_REQ  one-cycle pulse: requester's frame aborted by timeout.
- o_Busy  out  1  high in BUSY and GAP.
- o_Tx_Enable  out  1  to txshift i_Enable.
- o_Tx_Data  out  8  to txshift i_Data.
- i_Tx_Pready  in  1  from txshift o_Pready; rising edge marks frame done.

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer 0; gap and timeout counters 0; Pready history register 0.
- Reset mid-frame forces o_Tx_Enable low on the next edge, which aborts the txshift frame. No Ack or Err is issued.
- States: IDLE, BUSY, GAP.
- IDLE:
  - If any i_Req bit is set, select the first set bit searching upward from the pointer, with wrap.
  - On the next edge: state=BUSY, o_Grant=onehot(k), o_Tx_Data=i_Data[k] (latched), o_Tx_Enable=1, timeout counter=0.
  - Latency from request to enable is 1 cycle.
- BUSY:
  - Latched data is held constant; later i_Data changes and i_Req deassertion are ignored. There is no requester-side abort.
  - Edge detect: pready_rise = i_Tx_Pready & ~prev. prev updates every cycle in all states.
  - On pready_rise: the next edge gives o_Ack[k]=1 for one cycle, o_Tx_Enable=0, o_Grant=0, pointer=(k+1) mod NUM_REQ, state=GAP, gap counter=0.
  - Otherwise, when TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES-1: same transition, but pulse o_Err[k] instead of o_Ack[k].
  - If pready_rise and timeout occur in the same cycle, pready_rise wins (Ack only).
  - If Pready is already high on BUSY entry, it does not count; a fresh 0→1 is required.
- GAP:
  - o_Tx_Enable stays low for exactly max(GAP_CYCLES,1) cycles, then the state returns to IDLE.
  - i_Req is not sampled during GAP. This lets the acked requester drop or refresh its request.
- Back-to-back: with requests pending, consecutive enable rising edges are separated by frame time + GAP + 1 (IDLE arbitration cycle).
- Pointer advances only on completion or abort, never on reset-free idle.
- o_Ack and o_Err are mutually exclusive and never both set in one cycle.
- At most one o_Grant bit is set at any time.

Test Plan:
- Single request, NUM_REQ=4, real txshift, Baud=87: i_Req[2]=1, data 0x53 → o_Grant=4'b0100 and Enable 1 cycle after request. o_Tx_Data=0x53 stable until the Pready rise, then o_Ack[2] pulses for 1 cycle. Enable is low ≥16 cycles.
- Full contention: all four i_Req high, distinct bytes 0x11/0x22/0x33/0x44 → grants in order 0,1,2,3 with one Ack each. An rxshift loopback receives the same four bytes in order.
- Fairness: i_Req[0] and i_Req[3] held permanently, requesters re-arm after Ack → grants alternate 0,3,0,3 across 6 frames, with no starvation.
- Watchdog: stub Pready tied 0, TIMEOUT_CYCLES=100, i_Req[1]=1 → o_Err[1] pulses exactly 100 cycles after Enable rises, no Ack, pointer advances to 2. Also drive a Pready rise on the timeout cycle → Ack only.
- Reset mid-frame: assert i_Reset for 1 cycle halfway through a frame → next cycle all outputs 0, no Ack/Err. A subsequent request to 3 is granted before 0 only if 0 is idle, since the pointer restarts at 0.
- Data hold: change i_Data[0] and drop i_Req[0] during BUSY → o_Tx_Data is unchanged, the frame completes, and o_Ack[0] is still issued.

Source files
------------

// File: rtl/usrt_tx_arbiter_if.sv
// Signal bundle between the byte requesters, the round-robin arbiter and the
// txshift serializer it shares. The arbiter is the slave side.
interface usrt_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   i_Req;
  logic [8*NUM_REQ-1:0] i_Data;
  logic [NUM_REQ-1:0]   o_Grant;
  logic [NUM_REQ-1:0]   o_Ack;
  logic [NUM_REQ-1:0]   o_Err;
  logic                 o_Busy;
  logic                 o_Tx_Enable;
  logic [7:0]           o_Tx_Data;
  logic                 i_Tx_Pready;

  // Arbiter view: requests and serializer status in, grants and serializer controls out
  modport slave (
    input  i_Req, i_Data, i_Tx_Pready,
    output o_Grant, o_Ack, o_Err, o_Busy, o_Tx_Enable, o_Tx_Data
  );

  // Requester / serializer view of the same bundle
  modport master (
    output i_Req, i_Data, i_Tx_Pready,
    input  o_Grant, o_Ack, o_Err, o_Busy, o_Tx_Enable, o_Tx_Data
  );
endinterface

// File: rtl/usrt_tx_arbiter.sv
// Round-robin arbiter sharing one txshift serializer between NUM_REQ byte
// requesters. A granted byte is latched and the serializer enable held until
// the Pready rising edge (Ack) or the watchdog expiring (Err), followed by a
// fixed enable-low gap before the next arbitration.
module usrt_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic             i_Pclk,
  input  logic             i_Reset,
  usrt_tx_arbiter_if.slave bus
);

  localparam int          IDXW     = $clog2(NUM_REQ);
  localparam int          CW       = IDXW + 1;
  localparam int          GAP_EFF  = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
  localparam logic [15:0] GAP_LAST = 16'(GAP_EFF - 1);
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);
  localparam bit          TO_EN    = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

  state_t             state_q, state_d;
  logic [IDXW-1:0]    ptr_q, ptr_d;
  logic [IDXW-1:0]    own_q, own_d;
  logic [7:0]         txData_q, txData_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [NUM_REQ-1:0] err_q, err_d;
  logic [15:0]        gapCnt_q, gapCnt_d;
  logic [15:0]        toCnt_q, toCnt_d;
  logic               preadyPrev_q;

  logic [IDXW-1:0]    selIdx;
  logic               selValid;
  logic [CW-1:0]      cand;
  logic [7:0]         selByte;
  logic [IDXW-1:0]    nextPtr;
  logic               preadyRise;
  logic               timeoutHit;

  // First pending request at or above the pointer, wrapping past NUM_REQ-1
  always_comb begin
    selValid = 1'b0;
    selIdx   = '0;
    cand     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr_q} + CW'(i);
      if (cand >= CW'(NUM_REQ)) cand = cand - CW'(NUM_REQ);
      if (!selValid && bus.i_Req[cand[IDXW-1:0]]) begin
        selValid = 1'b1;
        selIdx   = cand[IDXW-1:0];
      end
    end
  end

  // Byte of the selected requester, pointer successor and frame-end conditions
  always_comb begin
    selByte = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (selIdx == IDXW'(j)) selByte = bus.i_Data[8*j +: 8];
    end
    nextPtr    = (own_q == IDXW'(NUM_REQ - 1)) ? '0 : own_q + IDXW'(1);
    preadyRise = bus.i_Tx_Pready & ~preadyPrev_q;
    timeoutHit = TO_EN && (toCnt_q == TO_LAST);
  end

  // State and datapath registers; reset drops the enable, cancelling any frame silently
  always_ff @(posedge i_Pclk) begin
    if (i_Reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      own_q        <= '0;
      txData_q     <= '0;
      ack_q        <= '0;
      err_q        <= '0;
      gapCnt_q     <= '0;
      toCnt_q      <= '0;
      preadyPrev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      own_q        <= own_d;
      txData_q     <= txData_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      gapCnt_q     <= gapCnt_d;
      toCnt_q      <= toCnt_d;
      preadyPrev_q <= bus.i_Tx_Pready;
    end
  end

  // Next state: arbitrate in IDLE, wait for Pready rise or watchdog in BUSY, count out GAP
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    own_d    = own_q;
    txData_d = txData_q;
    ack_d    = '0;
    err_d    = '0;
    gapCnt_d = gapCnt_q;
    toCnt_d  = toCnt_q;
    unique case (state_q)
      IDLE: begin
        if (selValid) begin
          state_d  = BUSY;
          own_d    = selIdx;
          txData_d = selByte;
          toCnt_d  = '0;
        end
      end
      BUSY: begin
        toCnt_d = toCnt_q + 16'd1;
        if (preadyRise || timeoutHit) begin
          state_d  = GAP;
          ptr_d    = nextPtr;
          gapCnt_d = '0;
          if (preadyRise) ack_d[own_q] = 1'b1;
          else            err_d[own_q] = 1'b1;
        end
      end
      GAP: begin
        gapCnt_d = gapCnt_q + 16'd1;
        if (gapCnt_q == GAP_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the registered state so they never glitch on input changes
  always_comb begin
    bus.o_Grant = '0;
    if (state_q == BUSY) bus.o_Grant[own_q] = 1'b1;
    bus.o_Tx_Enable = (state_q == BUSY);
    bus.o_Busy      = (state_q != IDLE);
    bus.o_Tx_Data   = txData_q;
    bus.o_Ack       = ack_q;
    bus.o_Err       = err_q;
  end

endmodule

// File: tb/tb_usrt_tx_arbiter.sv
// Scoreboard bench for usrt_tx_arbiter: stimulus pushes expected grants and
// completions, a negedge monitor pops and compares them as the DUT shows them.
module tb_usrt_tx_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int GAP       = 16;
  localparam int TIMEOUT   = 100;
  localparam int FRAME_LEN = 20;
  localparam int BUDGET    = 500;

  typedef struct {
    int         idx;
    logic [7:0] data;
  } grant_t;

  typedef struct {
    bit         isErr;
    int         idx;
    logic [7:0] data;
  } done_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   testsRun    = 0;
  int   testsFailed = 0;
  int   cycle       = 0;
  int   stubMode    = 0;
  logic manualPready = 1'b0;
  logic monEnPrev    = 1'b0;

  grant_t grantQ[$];
  done_t  doneQ[$];

  usrt_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  usrt_tx_arbiter #(
    .NUM_REQ(NUM_REQ),
    .GAP_CYCLES(GAP),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .i_Pclk(clk),
    .i_Reset(reset),
    .bus(bus)
  );

  // Free-running clock and a cycle counter used for latency measurements
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, actual, expected, cycle);
    end
  endtask

  task automatic timeoutFail(input string name);
    testsRun++;
    testsFailed++;
    $display("[TB] FAIL %s: no DUT response within %0d cycles (cycle %0d)", name, BUDGET, cycle);
  endtask

  task automatic applyStimulus(input logic [NUM_REQ-1:0] req, input logic [8*NUM_REQ-1:0] data);
    bus.i_Req  = req;
    bus.i_Data = data;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitEnable(input string name, output int atCycle);
    atCycle = -1;
    for (int n = 0; n < BUDGET; n++) begin
      @(posedge clk);
      #1;
      if (bus.o_Tx_Enable) begin
        atCycle = cycle;
        return;
      end
    end
    timeoutFail(name);
  endtask

  task automatic waitDone(input string name, output int atCycle);
    atCycle = -1;
    for (int n = 0; n < BUDGET; n++) begin
      @(posedge clk);
      #1;
      if ((bus.o_Ack | bus.o_Err) != '0) begin
        atCycle = cycle;
        return;
      end
    end
    timeoutFail(name);
  endtask

  task automatic waitNotBusy(input string name, output int cycles);
    cycles = 0;
    for (int n = 0; n < BUDGET; n++) begin
      @(posedge clk);
      #1;
      cycles++;
      if (!bus.o_Busy) return;
    end
    timeoutFail(name);
  endtask

  // txshift stand-in: Pready drops when a frame starts and rises FRAME_LEN cycles later;
  // mode 1 holds Pready low (hung serializer), mode 2 lets the stimulus drive it
  initial begin : txshiftStub
    int frameCnt;
    bit active;
    frameCnt = 0;
    active   = 1'b0;
    bus.i_Tx_Pready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (stubMode == 1) begin
        bus.i_Tx_Pready = 1'b0;
      end else if (stubMode == 2) begin
        bus.i_Tx_Pready = manualPready;
      end else if (!bus.o_Tx_Enable) begin
        active = 1'b0;
        bus.i_Tx_Pready = 1'b1;
      end else if (!active) begin
        active   = 1'b1;
        frameCnt = 0;
        bus.i_Tx_Pready = 1'b0;
      end else begin
        frameCnt++;
        if (frameCnt >= FRAME_LEN) bus.i_Tx_Pready = 1'b1;
      end
    end
  end

  // Monitor: each enable rise must match the next expected grant, each Ack/Err pulse the next expected completion
  always @(negedge clk) begin : monitor
    grant_t g;
    done_t  d;
    if (bus.o_Tx_Enable && !monEnPrev) begin
      if (grantQ.size() == 0) begin
        checkOutput("unexpected_grant", 32'(bus.o_Grant), 32'd0);
      end else begin
        g = grantQ.pop_front();
        checkOutput("grant_onehot", 32'(bus.o_Grant), 32'(1 << g.idx));
        checkOutput("grant_data", 32'(bus.o_Tx_Data), 32'(g.data));
      end
    end
    if ((bus.o_Ack | bus.o_Err) != '0) begin
      if (doneQ.size() == 0) begin
        checkOutput("unexpected_done", 32'({bus.o_Ack, bus.o_Err}), 32'd0);
      end else begin
        d = doneQ.pop_front();
        checkOutput("done_ack", 32'(bus.o_Ack), d.isErr ? 32'd0 : 32'(1 << d.idx));
        checkOutput("done_err", 32'(bus.o_Err), d.isErr ? 32'(1 << d.idx) : 32'd0);
        checkOutput("done_data", 32'(bus.o_Tx_Data), 32'(d.data));
      end
    end
    monEnPrev <= bus.o_Tx_Enable;
  end

  // Hard stop in case something hangs despite the per-wait budgets
  initial begin : globalWatchdog
    #400000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  // Directed scenarios
  initial begin : stimulus
    int tA;
    int tE;
    int gapLen;
    logic [NUM_REQ-1:0] reqMask;

    applyStimulus('0, '0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_grant", 32'(bus.o_Grant), 32'd0);
    checkOutput("rst_enable", 32'(bus.o_Tx_Enable), 32'd0);
    checkOutput("rst_busy", 32'(bus.o_Busy), 32'd0);
    checkOutput("rst_ack", 32'(bus.o_Ack), 32'd0);
    checkOutput("rst_err", 32'(bus.o_Err), 32'd0);
    checkOutput("rst_txdata", 32'(bus.o_Tx_Data), 32'd0);
    reset = 1'b0;
    waitCycles(1);

    $display("[TB] single request to requester 2");
    grantQ.push_back(grant_t'{2, 8'h53});
    doneQ.push_back(done_t'{1'b0, 2, 8'h53});
    applyStimulus(4'b0100, 32'h0053_0000);
    waitCycles(1);
    checkOutput("single_latency_enable", 32'(bus.o_Tx_Enable), 32'd1);
    checkOutput("single_grant", 32'(bus.o_Grant), 32'h4);
    waitDone("single_done", tA);
    applyStimulus('0, 32'h0053_0000);
    waitNotBusy("single_gap", gapLen);
    checkOutput("single_gap_len", 32'(gapLen), 32'(GAP));

    $display("[TB] data hold while busy");
    grantQ.push_back(grant_t'{0, 8'hA5});
    doneQ.push_back(done_t'{1'b0, 0, 8'hA5});
    applyStimulus(4'b0001, 32'h0000_00A5);
    waitEnable("hold_enable", tE);
    waitCycles(5);
    applyStimulus(4'b0000, 32'h0000_005A);
    waitCycles(1);
    checkOutput("hold_txdata", 32'(bus.o_Tx_Data), 32'hA5);
    checkOutput("hold_enable_kept", 32'(bus.o_Tx_Enable), 32'd1);
    waitDone("hold_done", tA);
    waitNotBusy("hold_gap", gapLen);

    $display("[TB] full contention after reset");
    reset = 1'b1;
    waitCycles(1);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      grantQ.push_back(grant_t'{k, 8'(8'h11 * (k + 1))});
      doneQ.push_back(done_t'{1'b0, k, 8'(8'h11 * (k + 1))});
    end
    reqMask = 4'b1111;
    applyStimulus(reqMask, 32'h4433_2211);
    for (int k = 0; k < 4; k++) begin
      waitDone("contention_done", tA);
      reqMask[k] = 1'b0;
      applyStimulus(reqMask, 32'h4433_2211);
      if (k < 3) begin
        waitEnable("contention_enable", tE);
        checkOutput("contention_spacing", 32'(tE - tA), 32'(GAP + 1));
      end
    end
    waitNotBusy("contention_gap", gapLen);

    $display("[TB] fairness between requesters 0 and 3");
    for (int k = 0; k < 6; k++) begin
      grantQ.push_back(grant_t'{(k % 2 == 1) ? 3 : 0, (k % 2 == 1) ? 8'h63 : 8'h60});
      doneQ.push_back(done_t'{1'b0, (k % 2 == 1) ? 3 : 0, (k % 2 == 1) ? 8'h63 : 8'h60});
    end
    applyStimulus(4'b1001, 32'h6300_0060);
    for (int k = 0; k < 6; k++) waitDone("fair_done", tA);
    applyStimulus('0, 32'h6300_0060);
    waitNotBusy("fair_gap", gapLen);

    $display("[TB] watchdog with hung serializer");
    stubMode = 1;
    grantQ.push_back(grant_t'{1, 8'h77});
    doneQ.push_back(done_t'{1'b1, 1, 8'h77});
    applyStimulus(4'b0010, 32'h0000_7700);
    waitEnable("wd_enable", tE);
    waitDone("wd_done", tA);
    checkOutput("wd_err_latency", 32'(tA - tE), 32'(TIMEOUT));
    applyStimulus('0, 32'h0000_7700);
    stubMode = 0;
    waitNotBusy("wd_gap", gapLen);

    $display("[TB] pointer advanced past aborted requester");
    grantQ.push_back(grant_t'{2, 8'hB2});
    doneQ.push_back(done_t'{1'b0, 2, 8'hB2});
    grantQ.push_back(grant_t'{0, 8'hB0});
    doneQ.push_back(done_t'{1'b0, 0, 8'hB0});
    applyStimulus(4'b0101, 32'h00B2_00B0);
    waitDone("ptr_done_first", tA);
    applyStimulus(4'b0001, 32'h00B2_00B0);
    waitDone("ptr_done_second", tA);
    applyStimulus('0, 32'h00B2_00B0);
    waitNotBusy("ptr_gap", gapLen);

    $display("[TB] Pready rise on the timeout cycle");
    manualPready = 1'b0;
    stubMode = 2;
    grantQ.push_back(grant_t'{1, 8'hC1});
    doneQ.push_back(done_t'{1'b0, 1, 8'hC1});
    applyStimulus(4'b0010, 32'h0000_C100);
    waitEnable("tie_enable", tE);
    waitCycles(TIMEOUT - 1);
    manualPready = 1'b1;
    waitDone("tie_done", tA);
    checkOutput("tie_latency", 32'(tA - tE), 32'(TIMEOUT));
    applyStimulus('0, 32'h0000_C100);
    stubMode = 0;
    waitNotBusy("tie_gap", gapLen);

    $display("[TB] reset in the middle of a frame");
    grantQ.push_back(grant_t'{2, 8'h42});
    applyStimulus(4'b0100, 32'h0042_0000);
    waitEnable("midrst_enable", tE);
    waitCycles(FRAME_LEN / 2);
    reset = 1'b1;
    applyStimulus('0, '0);
    waitCycles(1);
    reset = 1'b0;
    checkOutput("midrst_grant", 32'(bus.o_Grant), 32'd0);
    checkOutput("midrst_enable", 32'(bus.o_Tx_Enable), 32'd0);
    checkOutput("midrst_busy", 32'(bus.o_Busy), 32'd0);
    checkOutput("midrst_ackerr", 32'({bus.o_Ack, bus.o_Err}), 32'd0);
    checkOutput("midrst_txdata", 32'(bus.o_Tx_Data), 32'd0);
    waitCycles(FRAME_LEN);
    grantQ.push_back(grant_t'{0, 8'hD0});
    doneQ.push_back(done_t'{1'b0, 0, 8'hD0});
    grantQ.push_back(grant_t'{3, 8'hD3});
    doneQ.push_back(done_t'{1'b0, 3, 8'hD3});
    applyStimulus(4'b1001, 32'hD300_00D0);
    waitDone("midrst_done_first", tA);
    applyStimulus(4'b1000, 32'hD300_00D0);
    waitDone("midrst_done_second", tA);
    applyStimulus('0, 32'hD300_00D0);
    waitNotBusy("midrst_gap", gapLen);

    waitCycles(5);
    checkOutput("grant_queue_drained", 32'(grantQ.size()), 32'd0);
    checkOutput("done_queue_drained", 32'(doneQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
